// File: rtl/signed_multiplier_seq.sv
// signed_multiplier_seq
// Sequential 32x32 -> 64 signed multiplier using sign/magnitude shift-and-add.
// The operand magnitudes are multiplied unsigned over 32 CALC cycles, then the
// FIX cycle applies the result sign and registers the product.
// Optional build macro: EARLY_TERM_EN -- when defined, CALC stops as soon as
// the remaining multiplier has no set bits left, shortening latency for small
// |B| without changing the product value.

module signed_multiplier_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [63:0] P,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic [63:0] mcand;
   logic [31:0] mplier;
   logic [63:0] acc;
   logic [5:0]  count;
   logic        sign;

   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        calc_last;
   logic        calc_skip;

   // Operand magnitudes; negating 0x80000000 in 32 bits gives unsigned 2^31
   always_comb begin
      mag_a = A[31] ? (~A + 32'd1) : A;
      mag_b = B[31] ? (~B + 32'd1) : B;
   end

   // Decide whether this CALC cycle is the final one, and whether it is idle
   always_comb begin
      calc_last = (count == 6'd31);
`ifdef EARLY_TERM_EN
      calc_skip = (mplier == 32'd0);
      calc_last = calc_last | (mplier[31:1] == 31'd0);
`else
      calc_skip = 1'b0;
`endif
   end

   // Next-state decode for the IDLE -> CALC -> FIX -> DONE sequence
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (calc_last) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath: operand capture, shift-and-add iterations, sign fix-up into P
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= 64'd0;
         mplier <= 32'd0;
         acc    <= 64'd0;
         count  <= 6'd0;
         sign   <= 1'b0;
         P      <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {32'd0, mag_a};
                  mplier <= mag_b;
                  sign   <= A[31] ^ B[31];
                  acc    <= 64'd0;
                  count  <= 6'd0;
               end
            end
            CALC: begin
               if (!calc_skip) begin
                  if (mplier[0]) begin
                     acc <= acc + mcand;
                  end
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 6'd1;
               end
            end
            FIX: begin
               P <= sign ? (~acc + 64'd1) : acc;
            end
            default: begin
            end
         endcase
      end
   end

   // Registered status flags derived from the state being entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next == CALC) || (state_next == FIX);
         done <= (state_next == DONE);
      end
   end

endmodule

// File: tb/tb_signed_multiplier_seq.sv
// tb_signed_multiplier_seq
// Self-checking bench for signed_multiplier_seq. Expected products come from
// plain 64-bit signed arithmetic; expected latency follows EARLY_TERM_EN
// (fixed 33 cycles when undefined, 2 + highest set bit of |B| when defined).

module tb_signed_multiplier_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic [63:0] P;
   logic        busy;
   logic        done;

   int evaluated = 0;
   int failures  = 0;

   signed_multiplier_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycles from the accepting edge to the edge that raises done
   function automatic int expLatency(input logic [31:0] b);
      longint sb;
      longint mag;
      int hi;
      sb  = longint'($signed(b));
      mag = (sb < 0) ? -sb : sb;
      hi  = -1;
      for (int i = 0; i < 33; i++) begin
         if (((mag >> i) & 64'd1) != 0) hi = i;
      end
`ifdef EARLY_TERM_EN
      return (hi < 0) ? 2 : 2 + hi;
`else
      return 33;
`endif
   endfunction

   // Single comparison point: counts, asserts, and reports on mismatch
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      evaluated++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Run one multiplication and check product, done timing and busy window
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input bit hold, input string tag);
      longint expP;
      int     expLat;
      int     doneCount;
      int     firstDone;
      int     busyErr;
      expP   = longint'($signed(a)) * longint'($signed(b));
      expLat = expLatency(b);
      @(negedge clk);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      doneCount = 0;
      firstDone = -1;
      busyErr   = 0;
      if (busy !== 1'b1) busyErr++;
      for (int n = 1; n <= expLat + 1; n++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         A = $urandom;
         B = $urandom;
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            doneCount++;
            if (firstDone < 0) firstDone = n;
         end
         if (busy !== ((n < expLat) ? 1'b1 : 1'b0)) busyErr++;
      end
      start = 1'b0;
      checkOutput({tag, "_P"}, P, expP);
      checkOutput({tag, "_done_count"}, 64'(doneCount), 64'd1);
      checkOutput({tag, "_done_edge"}, 64'(firstDone), 64'(expLat));
      checkOutput({tag, "_busy_window"}, 64'(busyErr), 64'd0);
   endtask

   // Directed and random sequence
   initial begin
      int quietDone;
      rst   = 1'b1;
      start = 1'b0;
      A     = 32'd0;
      B     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_P", P, 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(32'd7, 32'd6, 1'b0, "7x6");
      applyStimulus(32'hFFFFFFFD, 32'd5, 1'b0, "m3x5");
      applyStimulus(32'h80000000, 32'h80000000, 1'b0, "minxmin");
      applyStimulus(32'h7FFFFFFF, 32'h80000000, 1'b1, "maxxmin_hold");
      applyStimulus(32'd12345, 32'd0, 1'b0, "bzero");
      applyStimulus(32'd12345, 32'd1, 1'b0, "bone");
      applyStimulus(32'd12345, 32'hFFFFFFFF, 1'b0, "bminus1");
      applyStimulus(32'h80000000, 32'h7FFFFFFF, 1'b0, "minxmax");

      // Reset during iteration ~10 abandons the operation silently
      @(negedge clk);
      A     = 32'd100;
      B     = 32'd100;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_P", P, 64'd0);
      checkOutput("rst_mid_busy", 64'(busy), 64'd0);
      checkOutput("rst_mid_done", 64'(done), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      quietDone = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) quietDone++;
      end
      checkOutput("rst_no_activity", 64'(quietDone), 64'd0);
      applyStimulus(32'd100, 32'd100, 1'b0, "after_rst");

      // Random operands, including small multipliers
      for (int i = 0; i < 8; i++) begin
         applyStimulus($urandom, $urandom, 1'b0, "rand");
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus($urandom, 32'($signed(-32'sd200 + 32'($urandom_range(0, 400)))), 1'b0, "rand_small");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
      $finish;
   end

endmodule
